// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if
//   Producer/consumer bundle for sync_fifo_flags.
//   master : drives flush, wr_en, wr_data, rd_en; observes data and status.
//   slave  : the FIFO side; drives rd_data, rd_valid, empty, full,
//            almost_empty, almost_full, count, overflow, underflow.
//   CW = $clog2(DEPTH)+1 is the occupancy/pointer width.
interface sync_fifo_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, programmable almost-empty /
//   almost-full levels, pass-through write on full, sticky overflow /
//   underflow, synchronous flush and an optional registered read port.
// Ports
//   CLK   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : sync_fifo_flags_if.slave (flush, write/read requests, read
//           data/valid, status flags, count, sticky error flags)
module sync_fifo_flags #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AE_LEVEL   = 1,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int OUTPUT_REG = 0
) (
  input logic              CLK,
  input logic              reset,
  sync_fifo_flags_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] AE_LV  = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_LV  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] FULL_LV = CW'(DEPTH);
  localparam logic [CW-1:0] ONE    = CW'(1'b1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] head_word;

  // Acceptance, next-state pointers, count, flags and registered read port.
  always_comb begin
    rd_acc     = 1'b0;
    wr_acc     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    head_word  = mem_q[rd_ptr_q[AW-1:0]];
    if (bus.flush) begin
      // Flush discards contents and requests; sticky flags survive.
      wr_ptr_d = {CW{1'b0}};
      rd_ptr_d = {CW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      rd_acc = bus.rd_en && !empty_q;
      // A read in the same cycle frees a slot, so a full FIFO still takes the write.
      wr_acc = bus.wr_en && (!full_q || rd_acc);
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ONE;
        rd_data_d  = head_word;
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
      ovf_d   = ovf_q | (bus.wr_en && !wr_acc);
      unf_d   = unf_q | (bus.rd_en && !rd_acc);
    end
    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == FULL_LV);
    ae_d    = (count_d <= AE_LV);
    af_d    = (count_d >= AF_LV);
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q   <= {CW{1'b0}};
      rd_ptr_q   <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ae_q       <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ae_q       <= ae_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end
  end

  // Output mux: show-ahead head word, or the registered read result.
  always_comb begin
    if (OUTPUT_REG != 0) begin
      bus.rd_data  = rd_data_q;
      bus.rd_valid = rd_valid_q;
    end else begin
      bus.rd_data  = empty_q ? {WIDTH{1'b0}} : head_word;
      bus.rd_valid = !empty_q;
    end
  end

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  // A: DEPTH=4 show-ahead, default levels. B: DEPTH=8 registered, AE=2, AF=6.
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(4)) a_if ();
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(8)) b_if ();

  sync_fifo_flags #(.WIDTH(8), .DEPTH(4)) dut_a (
    .CLK(CLK), .reset(reset), .bus(a_if.slave));
  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AE_LEVEL(2), .AF_LEVEL(6), .OUTPUT_REG(1)) dut_b (
    .CLK(CLK), .reset(reset), .bus(b_if.slave));

  int tests = 0;
  int fails = 0;

  logic [7:0] ma[$];   // reference contents, A
  logic [7:0] mb[$];   // reference contents, B
  logic [7:0] exa[$];  // scoreboard of expected read words, A
  logic [7:0] exb[$];  // scoreboard of expected read words, B
  bit a_ovf, a_unf, b_ovf, b_unf, b_vexp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_all();
    reset = 1'b1;
    a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.wr_data = 8'h00;
    b_if.flush = 1'b0; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.wr_data = 8'h00;
    ma.delete(); mb.delete(); exa.delete(); exb.delete();
    a_ovf = 1'b0; a_unf = 1'b0; b_ovf = 1'b0; b_unf = 1'b0; b_vexp = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  task automatic stat_a(input string tag);
    int n;
    n = ma.size();
    chk({tag, " a.count"}, 32'(a_if.count), n);
    chk({tag, " a.empty"}, 32'(a_if.empty), 32'(n == 0));
    chk({tag, " a.full"}, 32'(a_if.full), 32'(n == 4));
    chk({tag, " a.almost_empty"}, 32'(a_if.almost_empty), 32'(n <= 1));
    chk({tag, " a.almost_full"}, 32'(a_if.almost_full), 32'(n >= 3));
    chk({tag, " a.overflow"}, 32'(a_if.overflow), 32'(a_ovf));
    chk({tag, " a.underflow"}, 32'(a_if.underflow), 32'(a_unf));
    chk({tag, " a.rd_valid"}, 32'(a_if.rd_valid), 32'(n != 0));
    if (n == 0) chk({tag, " a.rd_data_empty"}, 32'(a_if.rd_data), 32'h0);
  endtask

  task automatic stat_b(input string tag);
    int n;
    n = mb.size();
    chk({tag, " b.count"}, 32'(b_if.count), n);
    chk({tag, " b.empty"}, 32'(b_if.empty), 32'(n == 0));
    chk({tag, " b.full"}, 32'(b_if.full), 32'(n == 8));
    chk({tag, " b.almost_empty"}, 32'(b_if.almost_empty), 32'(n <= 2));
    chk({tag, " b.almost_full"}, 32'(b_if.almost_full), 32'(n >= 6));
    chk({tag, " b.overflow"}, 32'(b_if.overflow), 32'(b_ovf));
    chk({tag, " b.underflow"}, 32'(b_if.underflow), 32'(b_unf));
    chk({tag, " b.rd_valid"}, 32'(b_if.rd_valid), 32'(b_vexp));
  endtask

  // One cycle on A: check current status, advance model, drive, clock.
  task automatic step_a(input string tag, input bit fl, input bit we,
                        input logic [7:0] wd, input bit re);
    bit racc, wacc;
    stat_a(tag);
    racc = 1'b0; wacc = 1'b0;
    if (fl) begin
      ma.delete();
    end else begin
      racc = re && (ma.size() > 0);
      wacc = we && ((ma.size() < 4) || racc);
      if (racc) exa.push_back(ma.pop_front());
      if (wacc) ma.push_back(wd);
      if (we && !wacc) a_ovf = 1'b1;
      if (re && !racc) a_unf = 1'b1;
    end
    a_if.flush = fl; a_if.wr_en = we; a_if.wr_data = wd; a_if.rd_en = re;
    @(posedge CLK);
    #1;
    a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
  endtask

  task automatic step_b(input string tag, input bit fl, input bit we,
                        input logic [7:0] wd, input bit re, output bit wacc);
    bit racc;
    stat_b(tag);
    racc = 1'b0; wacc = 1'b0;
    if (fl) begin
      mb.delete();
    end else begin
      racc = re && (mb.size() > 0);
      wacc = we && ((mb.size() < 8) || racc);
      if (racc) exb.push_back(mb.pop_front());
      if (wacc) mb.push_back(wd);
      if (we && !wacc) b_ovf = 1'b1;
      if (re && !racc) b_unf = 1'b1;
    end
    b_vexp = racc;
    b_if.flush = fl; b_if.wr_en = we; b_if.wr_data = wd; b_if.rd_en = re;
    @(posedge CLK);
    #1;
    b_if.flush = 1'b0; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0;
  endtask

  // Monitor A: a show-ahead word is consumed when rd_en meets rd_valid.
  always @(negedge CLK) begin
    if (!reset && !a_if.flush && a_if.rd_en && a_if.rd_valid) begin
      if (exa.size() == 0) chk("a unexpected read", 32'(a_if.rd_data), 32'hFFFF_FFFF);
      else chk("a rd_data", 32'(a_if.rd_data), 32'(exa.pop_front()));
    end
  end

  // Monitor B: every rd_valid pulse presents one expected word.
  always @(negedge CLK) begin
    if (!reset && b_if.rd_valid) begin
      if (exb.size() == 0) chk("b unexpected rd_valid", 32'(b_if.rd_data), 32'hFFFF_FFFF);
      else chk("b rd_data", 32'(b_if.rd_data), 32'(exb.pop_front()));
    end
  end

  initial begin
    bit wa;
    int nxt;
    int guard;
    reset_all();

    // Reset state on both instances.
    chk("b reset rd_data", 32'(b_if.rd_data), 32'h0);
    step_a("t1", 1'b0, 1'b0, 8'h00, 1'b0);
    step_b("t1", 1'b0, 1'b0, 8'h00, 1'b0, wa);

    // Fill to full, overflow on 5th write, drain in order.
    for (int i = 0; i < 5; i++) step_a("t2 fill", 1'b0, 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step_a("t2 drain", 1'b0, 1'b0, 8'h00, 1'b1);
    step_a("t2 end", 1'b0, 1'b0, 8'h00, 1'b0);

    // Pass-through on full.
    reset_all();
    for (int i = 0; i < 4; i++) step_a("t3 fill", 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    step_a("t3 pass", 1'b0, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) step_a("t3 drain", 1'b0, 1'b0, 8'h00, 1'b1);
    step_a("t3 end", 1'b0, 1'b0, 8'h00, 1'b0);

    // Underflow, then write+read on empty: no bypass.
    step_a("t4 rd", 1'b0, 1'b0, 8'h00, 1'b1);
    step_a("t4 wr_rd", 1'b0, 1'b1, 8'h11, 1'b1);
    step_a("t4 rd11", 1'b0, 1'b0, 8'h00, 1'b1);
    step_a("t4 end", 1'b0, 1'b0, 8'h00, 1'b0);

    // Flush keeps sticky overflow; reset clears it.
    for (int i = 0; i < 5; i++) step_a("t6 fill", 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    step_a("t6 flush", 1'b1, 1'b1, 8'h77, 1'b1);
    step_a("t6 after", 1'b0, 1'b0, 8'h00, 1'b0);
    reset_all();
    step_a("t6 reset", 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic on A with occasional flush.
    for (int i = 0; i < 300; i++)
      step_a("ra", ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
             8'($urandom), ($urandom_range(0, 1) == 1));
    for (int i = 0; i < 5; i++) step_a("ra drain", 1'b0, 1'b0, 8'h00, 1'b1);
    step_a("ra end", 1'b0, 1'b0, 8'h00, 1'b0);

    // Stream 0..255 through B with random gaps.
    nxt = 0;
    guard = 0;
    while (nxt < 256 && guard < 5000) begin
      step_b("t5", 1'b0, ($urandom_range(0, 2) != 0), 8'(nxt), ($urandom_range(0, 2) == 0), wa);
      if (wa) nxt++;
      guard++;
    end
    chk("b stream completed", 32'(nxt), 32'd256);
    guard = 0;
    while (mb.size() > 0 && guard < 100) begin
      step_b("t5 drain", 1'b0, 1'b0, 8'h00, 1'b1, wa);
      guard++;
    end
    step_b("t5 idle", 1'b0, 1'b0, 8'h00, 1'b0, wa);
    step_b("t5 end", 1'b0, 1'b0, 8'h00, 1'b0, wa);

    // Random B traffic with flushes and underflow.
    for (int i = 0; i < 200; i++)
      step_b("rb", ($urandom_range(0, 20) == 0), ($urandom_range(0, 1) == 1),
             8'($urandom), ($urandom_range(0, 1) == 1), wa);
    for (int i = 0; i < 10; i++) step_b("rb drain", 1'b0, 1'b0, 8'h00, 1'b1, wa);
    step_b("rb end", 1'b0, 1'b0, 8'h00, 1'b0, wa);
    @(negedge CLK);

    chk("a scoreboard empty", 32'(exa.size()), 32'd0);
    chk("b scoreboard empty", 32'(exb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
